mem_bus_bridge: RTL and testbench



---
 rtl/mem_bus_bridge_pkg.sv | 23 ++
 rtl/mem_bus_bridge_rr_arbiter.sv | 30 +++
 rtl/mem_bus_bridge.sv | 133 +++++++++++++
 tb/tb_mem_bus_bridge.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and sizing helpers for the N-master memory bus bridge.
package mem_bus_bridge_pkg;

   // Bridge transaction FSM: arbitrate, run the external bus cycle, report.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Width of the ack timeout counter; a disabled timeout still needs one bit.
   function automatic int tmo_cnt_w(input int timeout);
      if (timeout < 1) return 1;
      return $clog2(timeout + 1);
   endfunction

   // Width of a master index; a single master still needs one bit.
   function automatic int idx_w(input int n);
      if (n < 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mem_bus_bridge_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import mem_bus_bridge_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          valid
);

   logic [IW-1:0] idx;

   // Scan the request vector starting at the pointer and keep the first hit.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            valid = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/mem_bus_bridge.sv
// N-master ready/valid to sel/ack memory bus bridge with round-robin
// arbitration and an ack timeout that completes the transaction with a fault.
// Handshake: a master holds read/write (plus address/mask/data) stable until
// it sees its one-cycle m_ready_o pulse and drops the request on that edge;
// externally sel_o stays high with stable fields until ack_i is sampled high.
module mem_bus_bridge
   import mem_bus_bridge_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          reset_i,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [N_MASTERS-1:0]          m_read_i,
   input  logic [N_MASTERS-1:0]          m_write_i,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wr_mask_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic [N_MASTERS-1:0]          m_ready_o,
   output logic [N_MASTERS-1:0]          m_fault_o,
   output logic                          sel_o,
   output logic [ADDR_W-1:0]             addr_o,
   output logic                          we_o,
   output logic [DATA_W/8-1:0]           wr_mask_o,
   output logic [DATA_W-1:0]             data_out_o,
   input  logic [DATA_W-1:0]             data_in_i,
   input  logic                          ack_i,
   output logic [1:0]                    state_dbg_o
);

   localparam int IW = idx_w(N_MASTERS);
   localparam int CW = tmo_cnt_w(TIMEOUT);
   localparam int MW = DATA_W / 8;
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTERS - 1);

   state_t              state;
   state_t              state_next;
   logic [N_MASTERS-1:0] req;
   logic [IW-1:0]       arb_idx;
   logic                arb_valid;
   logic [IW-1:0]       grant;
   logic [IW-1:0]       rr_ptr;
   logic [CW-1:0]       tmo_cnt;
   logic                tmo_hit;

   assign req         = m_read_i | m_write_i;
   assign state_dbg_o = state;
   // The timeout fires on the last of TIMEOUT sel_o cycles; ack_i wins that cycle.
   assign tmo_hit     = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

   rr_arbiter #(
      .N  (N_MASTERS),
      .IW (IW)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (arb_idx),
      .valid (arb_valid)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) state <= ST_IDLE;
      else          state <= state_next;
   end

   // Next-state: one IDLE cycle to arbitrate, BUS until ack or timeout, one RESP cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (arb_valid)         state_next = ST_BUS;
         ST_BUS:  if (ack_i || tmo_hit)  state_next = ST_RESP;
         ST_RESP:                        state_next = ST_IDLE;
         default:                        state_next = ST_IDLE;
      endcase
   end

   // Registered datapath: latch the winner's request, drive the bus, pulse the response.
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         grant      <= '0;
         rr_ptr     <= '0;
         tmo_cnt    <= '0;
         sel_o      <= 1'b0;
         we_o       <= 1'b0;
         addr_o     <= '0;
         wr_mask_o  <= '0;
         data_out_o <= '0;
         m_rdata_o  <= '0;
         m_ready_o  <= '0;
         m_fault_o  <= '0;
      end else begin
         m_ready_o <= '0;
         m_fault_o <= '0;
         unique case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  grant      <= arb_idx;
                  sel_o      <= 1'b1;
                  we_o       <= m_write_i[arb_idx];
                  addr_o     <= m_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
                  wr_mask_o  <= m_wr_mask_i[int'(arb_idx)*MW +: MW];
                  data_out_o <= m_wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
                  tmo_cnt    <= '0;
               end
            end
            ST_BUS: begin
               if (ack_i) begin
                  sel_o            <= 1'b0;
                  m_rdata_o        <= data_in_i;
                  m_ready_o[grant] <= 1'b1;
               end else if (tmo_hit) begin
                  sel_o            <= 1'b0;
                  m_rdata_o        <= '0;
                  m_ready_o[grant] <= 1'b1;
                  m_fault_o[grant] <= 1'b1;
               end else if (tmo_cnt != {CW{1'b1}}) begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            ST_RESP: begin
               rr_ptr <= (grant == LAST_IDX) ? '0 : grant + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge (4 masters, short timeout).
// The bench plays the masters and the external memory; a small model keeps
// the round-robin pointer and each master's pending request.
module tb_mem_bus_bridge;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int MW  = DW / 8;
   localparam int TMO = 4;

   logic              clk = 1'b0;
   logic              reset_i;
   logic [N*AW-1:0]   m_addr_i;
   logic [N-1:0]      m_read_i;
   logic [N-1:0]      m_write_i;
   logic [N*MW-1:0]   m_wr_mask_i;
   logic [N*DW-1:0]   m_wdata_i;
   logic [DW-1:0]     m_rdata_o;
   logic [N-1:0]      m_ready_o;
   logic [N-1:0]      m_fault_o;
   logic              sel_o;
   logic [AW-1:0]     addr_o;
   logic              we_o;
   logic [MW-1:0]     wr_mask_o;
   logic [DW-1:0]     data_out_o;
   logic [DW-1:0]     data_in_i;
   logic              ack_i;
   logic [1:0]        state_dbg_o;

   logic [AW-1:0]     m_addr  [N];
   logic [MW-1:0]     m_mask  [N];
   logic [DW-1:0]     m_wdata [N];

   int rr_ptr_m;
   int last_grant;
   int n_cmp;
   int n_err;

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign m_addr_i[gi*AW +: AW]    = m_addr[gi];
      assign m_wr_mask_i[gi*MW +: MW] = m_mask[gi];
      assign m_wdata_i[gi*DW +: DW]   = m_wdata[gi];
   end

   mem_bus_bridge #(
      .N_MASTERS (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT   (TMO)
   ) u_dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .m_addr_i    (m_addr_i),
      .m_read_i    (m_read_i),
      .m_write_i   (m_write_i),
      .m_wr_mask_i (m_wr_mask_i),
      .m_wdata_i   (m_wdata_i),
      .m_rdata_o   (m_rdata_o),
      .m_ready_o   (m_ready_o),
      .m_fault_o   (m_fault_o),
      .sel_o       (sel_o),
      .addr_o      (addr_o),
      .we_o        (we_o),
      .wr_mask_o   (wr_mask_o),
      .data_out_o  (data_out_o),
      .data_in_i   (data_in_i),
      .ack_i       (ack_i),
      .state_dbg_o (state_dbg_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic clear_reqs();
      m_read_i  = '0;
      m_write_i = '0;
   endtask

   task automatic set_req(input int i, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [MW-1:0] msk,
                          input logic [DW-1:0] d);
      m_read_i[i]  = rd;
      m_write_i[i] = wr;
      m_addr[i]    = a;
      m_mask[i]    = msk;
      m_wdata[i]   = d;
   endtask

   // Run one transaction from the model's expected winner. give_ack=0 lets it
   // time out. Returns the number of negedges spent waiting for sel_o.
   task automatic serve(input int lat, input bit give_ack, input logic [DW-1:0] rd,
                        output int waited);
      int g;
      int n_hold;
      logic [DW-1:0] exp_rd;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_flt;
      logic [AW+1+MW+DW-1:0] exp_bus;
      g = -1;
      waited = 0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (rr_ptr_m + k) % N;
         if (g < 0 && (m_read_i[j] || m_write_i[j])) g = j;
      end
      if (g < 0) begin
         n_cmp++; n_err++;
         $display("FAIL serve_setup: no pending request in model");
         return;
      end
      do begin
         @(negedge clk);
         waited++;
      end while (!sel_o && waited < 20);
      n_cmp++;
      if (sel_o !== 1'b1) begin
         n_err++;
         $display("FAIL sel_start: sel_o=%b want 1 within 20 cycles", sel_o);
         return;
      end
      exp_bus = {m_addr[g], m_write_i[g], m_mask[g], m_wdata[g]};
      n_cmp++;
      if ({addr_o, we_o, wr_mask_o, data_out_o} !== exp_bus) begin
         n_err++;
         $display("FAIL bus_fields: got addr=%h we=%b mask=%h data=%h want %h (master %0d)",
                  addr_o, we_o, wr_mask_o, data_out_o, exp_bus, g);
      end
      n_hold = give_ack ? lat : TMO;
      for (int c = 1; c < n_hold; c++) begin
         @(negedge clk);
         n_cmp++;
         if (sel_o !== 1'b1 || m_ready_o !== '0 ||
             {addr_o, we_o, wr_mask_o, data_out_o} !== exp_bus) begin
            n_err++;
            $display("FAIL bus_hold: cycle %0d sel_o=%b ready=%b want sel 1, ready 0, stable fields",
                     c, sel_o, m_ready_o);
         end
      end
      exp_rdy = '0;
      exp_flt = '0;
      exp_rdy[g] = 1'b1;
      if (give_ack) begin
         ack_i     = 1'b1;
         data_in_i = rd;
         exp_rd    = rd;
      end else begin
         exp_flt[g] = 1'b1;
         exp_rd     = '0;
      end
      @(negedge clk);
      ack_i     = 1'b0;
      data_in_i = $urandom;
      n_cmp++;
      if (sel_o !== 1'b0 || m_ready_o !== exp_rdy || m_fault_o !== exp_flt ||
          m_rdata_o !== exp_rd) begin
         n_err++;
         $display("FAIL response: sel=%b ready=%b fault=%b rdata=%h want sel 0 ready=%b fault=%b rdata=%h",
                  sel_o, m_ready_o, m_fault_o, m_rdata_o, exp_rdy, exp_flt, exp_rd);
      end
      m_read_i[g]  = 1'b0;
      m_write_i[g] = 1'b0;
      rr_ptr_m     = (g + 1) % N;
      last_grant   = g;
      @(negedge clk);
      n_cmp++;
      if (m_ready_o !== '0 || m_fault_o !== '0 || sel_o !== 1'b0) begin
         n_err++;
         $display("FAIL pulse_width: ready=%b fault=%b sel=%b want all 0 after response",
                  m_ready_o, m_fault_o, sel_o);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_i   = 1'b0;
      ack_i     = 1'b0;
      data_in_i = '0;
      clear_reqs();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
      rr_ptr_m   = 0;
      last_grant = -1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({sel_o, we_o, addr_o, wr_mask_o, data_out_o, m_rdata_o, m_ready_o, m_fault_o} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: sel=%b we=%b addr=%h mask=%h dout=%h rdata=%h ready=%b fault=%b want all 0",
                  sel_o, we_o, addr_o, wr_mask_o, data_out_o, m_rdata_o, m_ready_o, m_fault_o);
      end
      reset_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ack_ignored();
      ack_i     = 1'b1;
      data_in_i = 32'hA5A5_A5A5;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (sel_o !== 1'b0 || m_ready_o !== '0) begin
            n_err++;
            $display("FAIL ack_idle: sel=%b ready=%b want 0 with no request", sel_o, m_ready_o);
         end
      end
      ack_i = 1'b0;
   endtask

   task automatic test_read();
      int w;
      set_req(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
      serve(2, 1'b1, 32'hDEAD_BEEF, w);
   endtask

   task automatic test_write();
      int w;
      set_req(1, 1'b0, 1'b1, 32'h0000_0020, 4'b0011, 32'h1234_5678);
      serve(1, 1'b1, 32'h0BAD_F00D, w);
   endtask

   task automatic test_back_to_back();
      int w;
      set_req(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
      set_req(1, 1'b1, 1'b1, 32'h2000, 4'hC, 32'hCAFE_0001);
      for (int k = 0; k < 4; k++) begin
         serve(1, 1'b1, $urandom, w);
         n_cmp++;
         if (last_grant !== (k % 2)) begin
            n_err++;
            $display("FAIL b2b_order: txn %0d granted %0d want %0d", k, last_grant, k % 2);
         end
         if (k > 0) begin
            n_cmp++;
            if (w !== 1) begin
               n_err++;
               $display("FAIL b2b_gap: txn %0d waited %0d cycles want 1", k, w);
            end
         end
         if (last_grant == 0) set_req(0, 1'b1, 1'b0, 32'h1000 + k, 4'hF, 32'h0);
         else                 set_req(1, 1'b1, 1'b1, 32'h2000 + k, 4'hC, 32'hCAFE_0000 + k);
      end
      clear_reqs();
   endtask

   task automatic test_timeout();
      int w;
      set_req(2, 1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'h0);
      serve(0, 1'b0, '0, w);
      set_req(3, 1'b0, 1'b1, 32'h0000_0800, 4'b0101, 32'h5555_AAAA);
      serve(1, 1'b1, 32'h1111_2222, w);
      set_req(0, 1'b1, 1'b0, 32'h0000_0C00, 4'hF, 32'h0);
      serve(TMO, 1'b1, 32'h3333_4444, w);
   endtask

   task automatic test_rr4();
      int w;
      set_req(1, 1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
      serve(1, 1'b1, $urandom, w);
      set_req(1, 1'b1, 1'b0, 32'h0000_0014, 4'hF, 32'h0);
      set_req(3, 1'b0, 1'b1, 32'h0000_0030, 4'h8, 32'h7777_0000);
      serve(1, 1'b1, $urandom, w);
      n_cmp++;
      if (last_grant !== 3) begin
         n_err++;
         $display("FAIL rr4_first: granted %0d want 3", last_grant);
      end
      serve(2, 1'b1, $urandom, w);
      n_cmp++;
      if (last_grant !== 1) begin
         n_err++;
         $display("FAIL rr4_second: granted %0d want 1", last_grant);
      end
   endtask

   task automatic test_reset_mid_bus();
      int w;
      int t;
      set_req(0, 1'b1, 1'b0, 32'h0000_0050, 4'hF, 32'h0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!sel_o && t < 20);
      n_cmp++;
      if (sel_o !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_start: sel_o=%b want 1 before reset", sel_o);
      end
      reset_i = 1'b0;
      #1;
      n_cmp++;
      if (sel_o !== 1'b0 || m_ready_o !== '0 || addr_o !== '0) begin
         n_err++;
         $display("FAIL rst_mid_async: sel=%b ready=%b addr=%h want 0 immediately",
                  sel_o, m_ready_o, addr_o);
      end
      clear_reqs();
      repeat (2) begin
         @(negedge clk);
         n_cmp++;
         if (m_ready_o !== '0 || m_fault_o !== '0) begin
            n_err++;
            $display("FAIL rst_mid_noready: ready=%b fault=%b want 0", m_ready_o, m_fault_o);
         end
      end
      reset_i  = 1'b1;
      rr_ptr_m = 0;
      set_req(1, 1'b1, 1'b0, 32'h0000_0060, 4'hF, 32'h0);
      set_req(3, 1'b1, 1'b0, 32'h0000_0070, 4'hF, 32'h0);
      serve(1, 1'b1, $urandom, w);
      n_cmp++;
      if (last_grant !== 1) begin
         n_err++;
         $display("FAIL rst_ptr: granted %0d want 1 after reset", last_grant);
      end
      serve(1, 1'b1, $urandom, w);
   endtask

   task automatic test_random();
      int w;
      int r;
      bit any;
      for (int it = 0; it < 30; it++) begin
         any = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!(m_read_i[i] || m_write_i[i]) && $urandom_range(0, 1) == 1) begin
               r = $urandom_range(1, 3);
               set_req(i, r[0], r[1], $urandom, 4'($urandom_range(0, 15)), $urandom);
            end
            if (m_read_i[i] || m_write_i[i]) any = 1'b1;
         end
         if (!any) begin
            r = $urandom_range(0, N - 1);
            set_req(r, 1'b1, 1'b0, $urandom, 4'hF, $urandom);
         end
         serve($urandom_range(1, TMO), ($urandom_range(0, 5) != 0), $urandom, w);
      end
      clear_reqs();
      repeat (3) @(negedge clk);
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_ack_ignored();
      test_read();
      test_write();
      test_back_to_back();
      test_timeout();
      test_rr4();
      test_reset_mid_bus();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
